// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU instruction sequencer: step encoding, instruction
// class, and opcode classification helpers.
package alu_seq_pkg;

    localparam int OP_W = 5;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_DECODE,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_ILLEGAL
    } state_t;

    typedef enum logic [1:0] {
        K_BINARY,
        K_MULDIV,
        K_UNARY
    } kind_t;

    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_SHRA = 5'b01000;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b01001;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b01010;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01011;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;

    function automatic logic is_binary(input logic [OP_W-1:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
                          OP_SHRA, OP_SHL, OP_ROR, OP_ROL};
    endfunction

    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return op inside {OP_MUL, OP_DIV};
    endfunction

    function automatic logic is_unary(input logic [OP_W-1:0] op);
        return op inside {OP_NEG, OP_NOT};
    endfunction

endpackage

// File: rtl/reg_onehot_dec.sv
// Register index to one-hot select; indices beyond NUM_REGS-1 select nothing.
module reg_onehot_dec #(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                en,
    input  logic [IDX_W-1:0]    idx,
    output logic [NUM_REGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            onehot[i] = en && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// T0..T6 control-strobe sequencer for register-register ALU instructions.
// Optional macro SEQ_SINGLE_STEP_EN adds a Step input gating every non-idle step.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NUM_REGS  = 16,
    parameter int WORD_W    = 32,
    parameter int OPCODE_W  = 5,
    parameter int REG_IDX_W = $clog2(NUM_REGS)
) (
    input  logic                Clock,
    input  logic                Clear_n,
    input  logic                Start,
    input  logic                Mem_ready,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                Step,
`endif
    input  logic [WORD_W-1:0]   IR,
    output logic                PCout,
    output logic                MARin,
    output logic                IncPC,
    output logic                Zin,
    output logic                PCin,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                HIin,
    output logic                LOin,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic [OPCODE_W-1:0] Alu_op,
    output logic                Busy,
    output logic                Done,
    output logic                Illegal
);

    localparam int LOW_W = WORD_W - OPCODE_W - 3 * REG_IDX_W;

    state_t                 state;
    kind_t                  kind;
    logic                   pc_first;
    logic                   advance;
    logic [OPCODE_W-1:0]    opcode;
    logic [OP_W-1:0]        op5;
    logic [REG_IDX_W-1:0]   ra;
    logic [REG_IDX_W-1:0]   rb;
    logic [REG_IDX_W-1:0]   rc;
    logic                   rin_en;
    logic                   rout_en;
    logic [REG_IDX_W-1:0]   rin_idx;
    logic [REG_IDX_W-1:0]   rout_idx;
    logic                   unused_ir_bits;

    assign opcode = IR[WORD_W-1 -: OPCODE_W];
    assign ra     = IR[WORD_W-1-OPCODE_W -: REG_IDX_W];
    assign rb     = IR[WORD_W-1-OPCODE_W-REG_IDX_W -: REG_IDX_W];
    assign rc     = IR[WORD_W-1-OPCODE_W-2*REG_IDX_W -: REG_IDX_W];
    assign op5    = OP_W'(opcode);
    assign unused_ir_bits = ^IR[LOW_W-1:0];

`ifdef SEQ_SINGLE_STEP_EN
    assign advance = Step;
`else
    assign advance = 1'b1;
`endif

    // The instruction class is latched at DECODE so later steps need not re-decode.
    always_ff @(posedge Clock or negedge Clear_n) begin
        if (!Clear_n) begin
            state    <= S_IDLE;
            kind     <= K_BINARY;
            pc_first <= 1'b0;
        end else begin
            pc_first <= 1'b0;
            case (state)
                S_IDLE:   if (Start) state <= S_T0;
                S_T0: begin
                    if (advance) begin
                        state    <= S_T1;
                        pc_first <= 1'b1;
                    end
                end
                S_T1:     if (advance && Mem_ready) state <= S_T2;
                S_T2:     if (advance) state <= S_DECODE;
                S_DECODE: begin
                    if (advance) begin
                        if (is_muldiv(op5)) begin
                            kind  <= K_MULDIV;
                            state <= S_T3;
                        end else if (is_unary(op5)) begin
                            kind  <= K_UNARY;
                            state <= S_T4;
                        end else if (is_binary(op5)) begin
                            kind  <= K_BINARY;
                            state <= S_T3;
                        end else begin
                            state <= S_ILLEGAL;
                        end
                    end
                end
                S_T3:     if (advance) state <= S_T4;
                S_T4:     if (advance) state <= S_T5;
                S_T5:     if (advance) state <= (kind == K_MULDIV) ? S_T6 : S_IDLE;
                S_T6:     if (advance) state <= S_IDLE;
                // Illegal is a single-cycle flag even when single-stepping.
                S_ILLEGAL: state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        {PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout,
         IRin, Yin, Zlowout, Zhighout, HIin, LOin} = '0;
        rin_en   = 1'b0;
        rout_en  = 1'b0;
        rin_idx  = ra;
        rout_idx = rb;
        Alu_op   = '0;
        Busy     = (state != S_IDLE);
        Done     = 1'b0;
        Illegal  = 1'b0;
        case (state)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = pc_first;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                Yin      = 1'b1;
                rout_en  = 1'b1;
                rout_idx = (kind == K_MULDIV) ? ra : rb;
            end
            S_T4: begin
                Zin      = 1'b1;
                Alu_op   = opcode;
                rout_en  = 1'b1;
                rout_idx = (kind == K_BINARY) ? rc : rb;
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (kind == K_MULDIV) begin
                    LOin = 1'b1;
                end else begin
                    rin_en = 1'b1;
                    Done   = 1'b1;
                end
            end
            S_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                Done     = 1'b1;
            end
            S_ILLEGAL: Illegal = 1'b1;
            default: ;
        endcase
    end

    reg_onehot_dec #(.NUM_REGS(NUM_REGS), .IDX_W(REG_IDX_W)) u_rin_dec (
        .en     (rin_en),
        .idx    (rin_idx),
        .onehot (Rin)
    );

    reg_onehot_dec #(.NUM_REGS(NUM_REGS), .IDX_W(REG_IDX_W)) u_rout_dec (
        .en     (rout_en),
        .idx    (rout_idx),
        .onehot (Rout)
    );

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: vector table, hand sequences and
// randomized instructions against a per-instruction behavioural model.
`timescale 1ns/1ps
module tb_alu_op_sequencer;

    localparam int NR = 12;
    localparam int W  = 32;

    localparam logic [13:0] S_PCOUT  = 14'h2000;
    localparam logic [13:0] S_MARIN  = 14'h1000;
    localparam logic [13:0] S_INCPC  = 14'h0800;
    localparam logic [13:0] S_ZIN    = 14'h0400;
    localparam logic [13:0] S_PCIN   = 14'h0200;
    localparam logic [13:0] S_READ   = 14'h0100;
    localparam logic [13:0] S_MDRIN  = 14'h0080;
    localparam logic [13:0] S_MDROUT = 14'h0040;
    localparam logic [13:0] S_IRIN   = 14'h0020;
    localparam logic [13:0] S_YIN    = 14'h0010;
    localparam logic [13:0] S_ZLO    = 14'h0008;
    localparam logic [13:0] S_ZHI    = 14'h0004;
    localparam logic [13:0] S_HIIN   = 14'h0002;
    localparam logic [13:0] S_LOIN   = 14'h0001;

    logic Clock = 1'b0;
    logic Clear_n = 1'b0;
    logic Start = 1'b0;
    logic Mem_ready = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
    logic Step = 1'b1;
`endif
    logic [W-1:0] IR = '0;
    logic PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout;
    logic IRin, Yin, Zlowout, Zhighout, HIin, LOin;
    logic [NR-1:0] Rin, Rout;
    logic [4:0] Alu_op;
    logic Busy, Done, Illegal;

    int checks = 0;
    int errors = 0;
    logic [13:0] tr_strb [0:79];

    typedef struct {
        int done_idx;
        int ill_idx;
        logic [NR-1:0] yin;
        int yin_cnt;
        logic [NR-1:0] t4;
        logic [NR-1:0] rin;
        int lohi;
    } exp_t;

    typedef struct {
        logic [31:0] ir;
        int stalls;
        exp_t e;
    } vec_t;

    typedef struct {
        int done_idx, done_cnt, ill_idx, ill_cnt, end_idx;
        int yin_cnt, lo_cnt, hi_cnt, pcin_cnt, conflicts, alu_stray;
        logic [NR-1:0] yin, t4, rin;
        logic [4:0] alu_t4;
    } obs_t;

    alu_op_sequencer #(.NUM_REGS(NR), .WORD_W(W), .OPCODE_W(5)) dut (
        .Clock(Clock), .Clear_n(Clear_n), .Start(Start), .Mem_ready(Mem_ready),
`ifdef SEQ_SINGLE_STEP_EN
        .Step(Step),
`endif
        .IR(IR), .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin),
        .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .Yin(Yin), .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin),
        .LOin(LOin), .Rin(Rin), .Rout(Rout), .Alu_op(Alu_op), .Busy(Busy),
        .Done(Done), .Illegal(Illegal)
    );

    always #5 Clock = ~Clock;

    function automatic logic [13:0] strb();
        return {PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout,
                IRin, Yin, Zlowout, Zhighout, HIin, LOin};
    endfunction

    function automatic logic [63:0] all_out();
        return 64'({strb(), Rin, Rout, Alu_op, Busy, Done, Illegal});
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [NR-1:0] oh(input int i);
        return (i < NR) ? (NR'(1) << i) : '0;
    endfunction

    // Expected per-instruction outcome straight from the instruction class rules.
    function automatic exp_t model(input logic [31:0] ir, input int stalls);
        exp_t e;
        int op, ra, rb, rc;
        bit bin, md, un;
        op = int'(ir[31:27]);
        ra = int'(ir[26:23]);
        rb = int'(ir[22:19]);
        rc = int'(ir[18:15]);
        bin = (op >= 3 && op <= 11);
        md  = (op == 15 || op == 16);
        un  = (op == 17 || op == 18);
        e = '{-1, -1, '0, 0, '0, '0, 0};
        if (!(bin || md || un)) begin
            e.ill_idx = 4 + stalls;
            return e;
        end
        e.done_idx = (md ? 7 : (un ? 5 : 6)) + stalls;
        if (!un) begin
            e.yin = oh(md ? ra : rb);
            e.yin_cnt = 1;
        end
        e.t4   = oh(bin ? rc : rb);
        e.rin  = md ? '0 : oh(ra);
        e.lohi = md ? 1 : 0;
        return e;
    endfunction

    task automatic run(input logic [31:0] ir, input int stalls, input bit hold,
                       input int step_period, output obs_t o);
        int drivers;
        o = '{default: 0};
        o.done_idx = -1;
        o.ill_idx  = -1;
        o.end_idx  = -1;
        IR = ir;
        Mem_ready = 1'b1;
        Start = 1'b1;
        tick();
        Start = hold;
        for (int j = 0; j < 80; j++) begin
            Mem_ready = !(j >= 1 && j < 1 + stalls);
`ifdef SEQ_SINGLE_STEP_EN
            Step = ((j % step_period) == step_period - 1);
`endif
            tr_strb[j] = strb();
            if (Done) begin
                o.done_cnt++;
                if (o.done_idx < 0) o.done_idx = j;
            end
            if (Illegal) begin
                o.ill_cnt++;
                if (o.ill_idx < 0) o.ill_idx = j;
            end
            if (Yin) begin
                o.yin_cnt++;
                o.yin = Rout;
            end
            if (Zin && !PCout) begin
                o.t4 = Rout;
                o.alu_t4 = Alu_op;
            end else if (Alu_op != 0) begin
                o.alu_stray++;
            end
            o.rin |= Rin;
            if (LOin) o.lo_cnt++;
            if (HIin) o.hi_cnt++;
            if (PCin) o.pcin_cnt++;
            drivers = int'(PCout) + int'(Zlowout) + int'(Zhighout) + int'(MDRout) + int'(|Rout);
            if (drivers > 1) o.conflicts++;
            if (!Busy) begin
                o.end_idx = j;
                break;
            end
            tick();
        end
        Start = 1'b0;
        Mem_ready = 1'b1;
`ifdef SEQ_SINGLE_STEP_EN
        Step = 1'b1;
`endif
    endtask

    task automatic compare(input string tag, input logic [31:0] ir, input exp_t e, input obs_t o);
        bit legal;
        legal = (e.ill_idx < 0);
        chk({tag, ".done_idx"}, o.done_idx, e.done_idx);
        chk({tag, ".done_cnt"}, o.done_cnt, legal ? 1 : 0);
        chk({tag, ".ill_idx"}, o.ill_idx, e.ill_idx);
        chk({tag, ".ill_cnt"}, o.ill_cnt, legal ? 0 : 1);
        chk({tag, ".end_idx"}, o.end_idx, (legal ? e.done_idx : e.ill_idx) + 1);
        chk({tag, ".yin_rout"}, o.yin, e.yin);
        chk({tag, ".yin_cnt"}, o.yin_cnt, e.yin_cnt);
        chk({tag, ".t4_rout"}, o.t4, e.t4);
        chk({tag, ".alu_op"}, o.alu_t4, legal ? ir[31:27] : 5'd0);
        chk({tag, ".alu_stray"}, o.alu_stray, 0);
        chk({tag, ".rin"}, o.rin, e.rin);
        chk({tag, ".lo_cnt"}, o.lo_cnt, e.lohi);
        chk({tag, ".hi_cnt"}, o.hi_cnt, e.lohi);
        chk({tag, ".pcin_cnt"}, o.pcin_cnt, 1);
        chk({tag, ".bus_conflict"}, o.conflicts, 0);
    endtask

    initial begin
        obs_t o;
        exp_t e;
        vec_t tbl [10];
        logic [13:0] seq [8];
        logic [13:0] want;
        logic [31:0] ir;
        logic [4:0] op;
        int st;

        tbl[0] = '{32'h4891_8000, 0, '{6, -1, 12'h004, 1, 12'h008, 12'h002, 0}};
        tbl[1] = '{32'h7920_0000, 0, '{7, -1, 12'h004, 1, 12'h010, 12'h000, 1}};
        tbl[2] = '{32'h1AB3_8000, 3, '{9, -1, 12'h040, 1, 12'h080, 12'h020, 0}};
        tbl[3] = '{32'h89C8_0000, 0, '{5, -1, 12'h000, 0, 12'h200, 12'h008, 0}};
        tbl[4] = '{32'hF800_0000, 0, '{-1, 4, 12'h000, 0, 12'h000, 12'h000, 0}};
        tbl[5] = '{32'h2E8F_0000, 0, '{6, -1, 12'h002, 1, 12'h000, 12'h000, 0}};
        tbl[6] = '{32'h85E0_0000, 0, '{7, -1, 12'h800, 1, 12'h000, 12'h000, 1}};
        tbl[7] = '{32'h9010_0000, 1, '{6, -1, 12'h000, 0, 12'h004, 12'h001, 0}};
        tbl[8] = '{32'h0000_0000, 2, '{-1, 6, 12'h000, 0, 12'h000, 12'h000, 0}};
        tbl[9] = '{32'h5245_8000, 0, '{6, -1, 12'h100, 1, 12'h800, 12'h010, 0}};

        seq[0] = S_PCOUT | S_MARIN | S_INCPC | S_ZIN;
        seq[1] = S_ZLO | S_PCIN | S_READ | S_MDRIN;
        seq[2] = S_MDROUT | S_IRIN;
        seq[3] = '0;
        seq[4] = S_YIN;
        seq[5] = S_ZIN;
        seq[6] = S_ZLO;
        seq[7] = '0;

        #12;
        chk("reset.outputs", all_out(), 0);
        @(negedge Clock);
        Clear_n = 1'b1;
        repeat (3) begin
            tick();
            chk("idle.outputs", all_out(), 0);
        end

        // Table vectors; the illegal entry is followed by an immediate new Start.
        for (int i = 0; i < 10; i++) begin
            run(tbl[i].ir, tbl[i].stalls, 1'b0, 1, o);
            compare($sformatf("vec%0d", i), tbl[i].ir, tbl[i].e, o);
        end

        // Full strobe sequence of shl R1,R2,R3.
        run(32'h4891_8000, 0, 1'b0, 1, o);
        for (int s = 0; s < 8; s++)
            chk($sformatf("shl.strobes%0d", s), tr_strb[s], seq[s]);

        // Memory stall: PCin only in the first T1 cycle.
        run(32'h1AB3_8000, 3, 1'b0, 1, o);
        chk("stall.t1_first", tr_strb[1], seq[1]);
        for (int s = 2; s < 5; s++)
            chk($sformatf("stall.t1_hold%0d", s), tr_strb[s], seq[1] & ~S_PCIN);
        chk("stall.t2", tr_strb[5], seq[2]);
        chk("stall.done_idx", o.done_idx, 9);

        // mul writeback steps.
        run(32'h7920_0000, 0, 1'b0, 1, o);
        chk("mul.t5", tr_strb[6], S_ZLO | S_LOIN);
        chk("mul.t6", tr_strb[7], S_ZHI | S_HIIN);

        // Start held high through the instruction is ignored while busy.
        run(32'h4891_8000, 0, 1'b1, 1, o);
        compare("hold", 32'h4891_8000, tbl[0].e, o);

        // Asynchronous clear in T4.
        IR = 32'h4891_8000;
        Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (5) tick();
        chk("rst.in_t4", strb(), S_ZIN);
        #2 Clear_n = 1'b0;
        #1 chk("rst.async_outputs", all_out(), 0);
        tick();
        chk("rst.held_outputs", all_out(), 0);
        #2 Clear_n = 1'b1;
        repeat (4) begin
            tick();
            chk("rst.idle_after", all_out(), 0);
        end
        run(32'h4891_8000, 0, 1'b0, 1, o);
        compare("after_rst", 32'h4891_8000, tbl[0].e, o);

`ifdef SEQ_SINGLE_STEP_EN
        run(32'h4891_8000, 0, 1'b0, 3, o);
        chk("step.done_idx", o.done_idx, 18);
        chk("step.end_idx", o.end_idx, 21);
        for (int s = 0; s < 7; s++) begin
            for (int r = 0; r < 3; r++) begin
                want = seq[s];
                if (s == 1 && r > 0) want = want & ~S_PCIN;
                chk($sformatf("step.strobes%0d_%0d", s, r), tr_strb[3*s+r], want);
            end
        end
`endif

        // Randomized instructions against the model.
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 3))
                0: op = 5'($urandom_range(3, 11));
                1: op = 5'($urandom_range(15, 16));
                2: op = 5'($urandom_range(17, 18));
                default: op = 5'($urandom_range(0, 31));
            endcase
            ir = {op, 27'($urandom)};
            st = $urandom_range(0, 3);
            e = model(ir, st);
            run(ir, st, 1'b0, 1, o);
            compare($sformatf("rand%0d", n), ir, e, o);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Synthesisable control sequencer that replaces hand-timed bench stimulus.
- Generates the full T0..Tn control-strobe sequence for register-register ALU instructions on the shared-bus datapath.
- Parametrised in register-file size and word width. Supports 2-step HI/LO writeback for mul/div, unary ops, stall on memory, and illegal-opcode detection.
- Sits between the instruction register and the datapath's strobe inputs.

Parameters:
NUM_REGS, 16, register-file size; one-hot Rin/Rout width
WORD_W, 32, instruction width; IR field positions scale from the MSB
OPCODE_W, 5, opcode field width (IR[WORD_W-1 -: OPCODE_W])
REG_IDX_W, $clog2(NUM_REGS), register index field width

Ports:
Clock  in  1  system clock, rising edge
Clear_n  in  1  asynchronous active-low reset
Start  in  1  begin instruction; sampled only in IDLE
Mem_ready  in  1  memory data valid; T1 holds while low
IR  in  WORD_W  instruction register contents; fields: opcode, Ra, Rb, Rc from MSB down
PCout, MARin, IncPC, Zin, PCin, Read, MDRin, MDRout, IRin, Yin, Zlowout, Zhighout, HIin, LOin  out  1 each  datapath strobes
Rin  out  NUM_REGS  one-hot register load
Rout  out  NUM_REGS  one-hot register drive
Alu_op  out  OPCODE_W  ALU operation; equals IR opcode in T4, else 0
Busy  out  1  high from T0 through the final step
Done  out  1  one-cycle pulse in the final step
Illegal  out  1  one-cycle pulse on an unsupported opcode

Behaviour:
Reset and output style:
- Clear_n low: state returns to IDLE immediately; every output is 0.
- Reset mid-instruction aborts with no further strobes.
- Moore outputs, decoded from the registered state; at most one bus driver is active per state.

Timing:
- Start high in IDLE at edge k: T0 strobes are valid in cycle k+1.
- Start while Busy is ignored.

States:
- IDLE
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin, Read, MDRin. Holds while Mem_ready=0; PCin pulses only on the first T1 cycle.
- T2: MDRout, IRin.
- DECODE (1 cycle, no strobes): classify opcode.
  - Binary ops: add 00011, sub 00100, and 00101, or 00110, shr 00111, shra 01000, shl 01001, ror 01010, rol 01011 -> T3.
  - mul 01111, div 10000 -> T3.
  - neg 10001, not 10010 -> T4 directly.
  - Anything else -> Illegal pulse, then IDLE.
- T3: Rout[Rb], Yin. For mul/div, Rout[Ra].
- T4: Rout[Rc], Alu_op, Zin. For mul/div, Rout[Rb]; for unary ops, Rout[Rb].
- T5: Zlowout, Rin[Ra], Done. For mul/div: Zlowout, LOin, no Done.
- T6 (mul/div only): Zhighout, HIin, Done.
- Then IDLE.

Register indices:
- Index ≥ NUM_REGS (possible only when 2^REG_IDX_W > NUM_REGS) yields all-zero Rin/Rout for that step.
- The sequence still completes.

Cycle counts, Start to Done inclusive of T0:
- Binary op: 7 cycles.
- mul/div: 8 cycles.
- Unary op: 6 cycles.
- Each T1 stall cycle adds 1.

Optional Feature:
SEQ_SINGLE_STEP_EN:
- Defined: adds input Step. Every state other than IDLE advances only on a cycle with Step=1; strobes stay asserted while waiting. T1 still also requires Mem_ready.
- Undefined: no Step port; free-running as above.

Decomposition:
- Package alu_seq_pkg holds:
  - state enum;
  - opcode localparams (OP_ADD..OP_NOT);
  - function is_binary/is_muldiv/is_unary(opcode).
- Sub-module reg_onehot_dec: index -> NUM_REGS one-hot with enable and out-of-range zeroing. Instantiated twice, for Rin and Rout.

Test Plan:
- IR=32'h4891_8000 (shl R1,R2,R3), Start pulse, Mem_ready=1:
  - Rout=0x0004 plus Yin in T3;
  - Rout=0x0008, Alu_op=01001, Zin in T4;
  - Rin=0x0002, Zlowout, Done in T5;
  - Done exactly 7 cycles after the Start edge.
- IR opcode 01111 (mul R2,R4): T5 asserts LOin, T6 asserts HIin plus Done; Rin stays 0 throughout.
- Mem_ready held low 3 cycles in T1: T1 lasts 4 cycles; PCin high only in the first; Done arrives at cycle 10.
- Opcode 11111: Illegal pulses once after T2; no T3 strobes; Busy drops; a new Start is accepted next cycle.
- Clear_n asserted during T4: all outputs 0 asynchronously; after release, idle until Start.
- With SEQ_SINGLE_STEP_EN: Step pulsed every 3rd cycle; each state holds 3 cycles; strobe sequence identical to the first scenario.
